// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router control slice.
package router_pkg;

  localparam int unsigned NUM_PORTS    = 3;
  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned TIMEOUT_DFLT = 30;
  localparam int unsigned CNT_W_DFLT   = 5;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_INVALID = 2'b11;

  // Destination address to one-hot FIFO select; the invalid address selects nothing.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input addr_t addr);
    logic [NUM_PORTS-1:0] sel;
    sel = '0;
    case (addr)
      2'b00:   sel = 3'b001;
      2'b01:   sel = 3'b010;
      2'b10:   sel = 3'b100;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_wdog.sv
// Per-port read watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles in which the port holds data that nobody reads.
module router_wdog #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;
  logic             idle;
  logic             at_limit;

  assign idle     = vld & ~rd;
  assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

  // Count only unbroken idle runs; any read or drained FIFO restarts the window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!idle) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (at_limit) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_ctrl.sv
// Glue between router_fsm and the three output FIFOs: address latch, write
// steering, full-flag return, port valid flags and read watchdogs.
module router_sync_ctrl
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DFLT,
  parameter int unsigned CNT_W   = CNT_W_DFLT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  addr_t addr_q;

  // Header capture; the invalid address is latched too so stray writes go nowhere.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= ADDR_INVALID;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // Decode from the registered address so a same-cycle header does not redirect the write.
  always_comb begin
    write_enb = '0;
    if (write_enb_reg) begin
      write_enb = addr_onehot(addr_q);
    end
  end

  always_comb begin
    fifo_full = 1'b0;
    case (addr_q)
      2'b00:   fifo_full = full_0;
      2'b01:   fifo_full = full_1;
      2'b10:   fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  router_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog_0 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_0),
    .rd         (read_enb_0),
    .soft_reset (soft_reset_0)
  );

  router_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog_1 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_1),
    .rd         (read_enb_1),
    .soft_reset (soft_reset_1)
  );

  router_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog_2 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_2),
    .rd         (read_enb_2),
    .soft_reset (soft_reset_2)
  );

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Scoreboard bench for router_sync_ctrl: stimulus queues one expected output
// record per cycle, a negedge monitor pops and compares.
module tb_router_sync_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  typedef struct {
    string      name;
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
    logic [2:0] sr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  router_sync_ctrl dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected valids are the complement of the empties the stimulus just drove.
  task automatic push(input string name, input logic [2:0] we, input logic ff,
                      input logic [2:0] sr);
    exp_t e;
    e.name = name;
    e.we   = we;
    e.ff   = ff;
    e.vld  = ~{empty_2, empty_1, empty_0};
    e.sr   = sr;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input string field, input logic [2:0] act,
                     input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%b expected=%b at %0t", name, field, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "write_enb", write_enb, e.we);
      cmp(e.name, "fifo_full", {2'b00, fifo_full}, {2'b00, e.ff});
      cmp(e.name, "vld_out", {vld_out_2, vld_out_1, vld_out_0}, e.vld);
      cmp(e.name, "soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, e.sr);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn        = 1'b0;
    detect_add    = 1'b0;
    data_in       = 2'b00;
    write_enb_reg = 1'b1;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b010;
    {empty_2, empty_1, empty_0}          = 3'b101;
    {full_2, full_1, full_0}             = 3'b111;

    // Reset state: invalid address masks write and full; valids track empties.
    tick();
    push("reset", 3'b000, 1'b0, 3'b000);

    tick();
    resetn = 1'b1;
    write_enb_reg = 1'b0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0}          = 3'b111;
    push("post_reset", 3'b000, 1'b0, 3'b000);

    // 1: latch address 01, then write goes to FIFO 1 and full follows full_1.
    tick();
    detect_add = 1'b1; data_in = 2'b01; {full_2, full_1, full_0} = 3'b010;
    push("t1_hdr", 3'b000, 1'b0, 3'b000);
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    push("t1_wr", 3'b010, 1'b1, 3'b000);
    tick();
    {full_2, full_1, full_0} = 3'b000;
    push("t1_notfull", 3'b010, 1'b0, 3'b000);
    tick();
    {full_2, full_1, full_0} = 3'b101;
    push("t1_others_full", 3'b010, 1'b0, 3'b000);

    // 2: invalid address latched; all writes and full flags masked.
    tick();
    detect_add = 1'b1; data_in = 2'b11; {full_2, full_1, full_0} = 3'b111;
    push("t2_hdr", 3'b010, 1'b1, 3'b000);
    tick();
    detect_add = 1'b0;
    push("t2_invalid", 3'b000, 1'b0, 3'b000);

    // 3: header and write on the same edge use the old address.
    tick();
    detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b0;
    push("t3_hdr00", 3'b000, 1'b0, 3'b000);
    tick();
    data_in = 2'b10; write_enb_reg = 1'b1; {full_2, full_1, full_0} = 3'b001;
    push("t3_same_edge", 3'b001, 1'b1, 3'b000);
    tick();
    detect_add = 1'b0;
    push("t3_next_wr", 3'b100, 1'b0, 3'b000);
    tick();
    {full_2, full_1, full_0} = 3'b100;
    push("t3_full2", 3'b100, 1'b1, 3'b000);
    tick();
    write_enb_reg = 1'b0; {full_2, full_1, full_0} = 3'b000;
    push("t3_idle", 3'b000, 1'b0, 3'b000);

    // 4: port 1 unread; pulse on the 30th idle edge, one cycle wide.
    for (int i = 0; i <= 32; i++) begin
      tick();
      empty_1 = 1'b0;
      push($sformatf("t4_c%0d", i), 3'b000, 1'b0, (i == 30) ? 3'b010 : 3'b000);
    end
    tick();
    empty_1 = 1'b1;
    push("t4_drain", 3'b000, 1'b0, 3'b000);

    // 5: port 2 read at cycle 29 restarts the window.
    for (int i = 0; i <= 61; i++) begin
      tick();
      empty_2    = 1'b0;
      read_enb_2 = (i == 29);
      push($sformatf("t5_c%0d", i), 3'b000, 1'b0, (i == 60) ? 3'b100 : 3'b000);
    end
    tick();
    empty_2 = 1'b1; read_enb_2 = 1'b0;
    push("t5_drain", 3'b000, 1'b0, 3'b000);

    // 6: port 0 counter at 20 when reset hits mid-cycle; full window needed after.
    for (int i = 0; i < 20; i++) begin
      tick();
      empty_0 = 1'b0; write_enb_reg = 1'b1; {full_2, full_1, full_0} = 3'b100;
      push($sformatf("t6_c%0d", i), 3'b100, 1'b1, 3'b000);
    end
    tick();
    resetn = 1'b0;
    push("t6_async_rst", 3'b000, 1'b0, 3'b000);
    #6;
    resetn = 1'b1;
    for (int i = 21; i <= 51; i++) begin
      tick();
      push($sformatf("t6_c%0d", i), 3'b000, 1'b0, (i == 50) ? 3'b001 : 3'b000);
    end

    @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
